restoring_divider: RTL and testbench

RESTORING_DIVIDER -- requirements
Module: restoring_divider

---
 rtl/div_pkg.sv | 6 +
 rtl/div_bit_counter.sv | 22 ++
 rtl/restoring_divider.sv | 166 ++++++++++++++++
 tb/tb_restoring_divider.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared width, watchdog limit and FSM state type for restoring_divider
package div_pkg;
    localparam int WIDTH          = 16;
    localparam int TIMEOUT_CYCLES = 15;
    typedef enum logic [2:0] {IDLE, SHIFT, ISSUE, WAIT, DONE} div_state_t;
endpackage

// File: rtl/div_bit_counter.sv
// div_bit_counter: 5-bit iteration counter with clear/increment and terminal count at 16
//   clk, rst : clock, asynchronous active-high reset
//   clr_i    : synchronous clear (dominates increment)
//   inc_i    : count one completed quotient bit
//   tc_o     : high when the count is 16, or becomes 16 at the next edge
module div_bit_counter (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic inc_i,
    output logic tc_o
);
    logic [4:0] cnt_q, cnt_d;
    always_comb begin
        cnt_d = clr_i ? 5'd0 : cnt_q + {4'd0, inc_i};
        tc_o  = cnt_d == 5'd16;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/restoring_divider.sv
// restoring_divider: 16-bit unsigned restoring divider driving an external registered subtractor
//   clk, rst              : clock, asynchronous active-high reset
//   start                 : begin division (sampled only in IDLE)
//   Dividend, Divisor     : operands captured on an accepted start
//   Sub_Enable            : one-cycle request to the external subtractor
//   Sub_A, Sub_B          : minuend / subtrahend, stable until Sub_FLAG returns
//   Sub_Result, Sub_FLAG  : subtractor difference and its result-valid pulse
//   Quotient, Remainder   : results, held until the next completion
//   Done, Busy            : completion pulse, high outside IDLE
//   Div_By_Zero, Timeout  : sticky status, cleared on an accepted start
// Macro DIV_TIMEOUT_EN enables a watchdog that abandons WAIT after TIMEOUT_CYCLES.
module restoring_divider
    import div_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] Dividend,
    input  logic [15:0] Divisor,
    output logic        Sub_Enable,
    output logic [15:0] Sub_A,
    output logic [15:0] Sub_B,
    input  logic [15:0] Sub_Result,
    input  logic        Sub_FLAG,
    output logic [15:0] Quotient,
    output logic [15:0] Remainder,
    output logic        Done,
    output logic        Busy,
    output logic        Div_By_Zero,
    output logic        Timeout
);
    div_state_t        state_q, state_d;
    logic [WIDTH:0]    r_q, r_d;
    logic [WIDTH-1:0]  q_q, q_d, d_q, d_d, quot_q, quot_d, rem_q, rem_d;
    logic              dz_q, dz_d, qbit, bit_inc, bit_clr, bit_tc;
`ifdef DIV_TIMEOUT_EN
    logic [3:0]        wcnt_q, wcnt_d;
    logic              to_q, to_d;
`endif

    // R[16] is the carry out of the shift: when set, R already exceeds D
    assign qbit    = r_q[WIDTH] | (r_q[WIDTH-1:0] >= d_q);
    assign bit_inc = (state_q == WAIT) & Sub_FLAG;
    assign bit_clr = state_q == IDLE;

    div_bit_counter u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr_i(bit_clr),
        .inc_i(bit_inc),
        .tc_o (bit_tc)
    );

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
`ifdef DIV_TIMEOUT_EN
        wcnt_d  = wcnt_q;
        to_d    = to_q;
`endif
        case (state_q)
            IDLE: if (start) begin
                q_d  = Dividend;
                r_d  = '0;
                d_d  = Divisor;
                dz_d = 1'b0;
`ifdef DIV_TIMEOUT_EN
                to_d = 1'b0;
`endif
                if (Divisor == '0) begin
                    state_d = DONE;
                    dz_d    = 1'b1;
                    quot_d  = '1;
                    rem_d   = Dividend;
                end else begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                {r_d, q_d} = {r_q[WIDTH-1:0], q_q, 1'b0};
                state_d    = ISSUE;
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef DIV_TIMEOUT_EN
                wcnt_d  = '0;
`endif
            end
            WAIT: if (Sub_FLAG) begin
                if (qbit) begin
                    r_d    = {1'b0, Sub_Result};
                    q_d[0] = 1'b1;
                end
                // results are latched on the way into DONE so they line up with the Done pulse
                if (bit_tc) begin
                    state_d = DONE;
                    quot_d  = q_d;
                    rem_d   = r_d[WIDTH-1:0];
                end else begin
                    state_d = SHIFT;
                end
            end
`ifdef DIV_TIMEOUT_EN
            else if (wcnt_q == 4'(TIMEOUT_CYCLES - 1)) begin
                state_d = DONE;
                to_d    = 1'b1;
                quot_d  = '0;
                rem_d   = '0;
            end else begin
                wcnt_d = wcnt_q + 4'd1;
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
        end
    end

`ifdef DIV_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt_q <= '0;
            to_q   <= 1'b0;
        end else begin
            wcnt_q <= wcnt_d;
            to_q   <= to_d;
        end
    end
    assign Timeout = to_q;
`else
    assign Timeout = 1'b0;
`endif

    assign Sub_Enable  = state_q == ISSUE;
    assign Sub_A       = r_q[WIDTH-1:0];
    assign Sub_B       = d_q;
    assign Quotient    = quot_q;
    assign Remainder   = rem_q;
    assign Done        = state_q == DONE;
    assign Busy        = state_q != IDLE;
    assign Div_By_Zero = dz_q;
endmodule

// File: tb/tb_restoring_divider.sv
// tb_restoring_divider: directed table-driven checks of restoring_divider with a 1-cycle subtractor model
module tb_restoring_divider;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [15:0] Dividend = '0, Divisor = '0;
    logic        Sub_Enable, Sub_FLAG, Done, Busy, Div_By_Zero, Timeout;
    logic [15:0] Sub_A, Sub_B, Sub_Result, Quotient, Remainder;
    logic        resp_en = 1'b1;

    restoring_divider dut (
        .clk(clk), .rst(rst), .start(start), .Dividend(Dividend), .Divisor(Divisor),
        .Sub_Enable(Sub_Enable), .Sub_A(Sub_A), .Sub_B(Sub_B), .Sub_Result(Sub_Result),
        .Sub_FLAG(Sub_FLAG), .Quotient(Quotient), .Remainder(Remainder), .Done(Done),
        .Busy(Busy), .Div_By_Zero(Div_By_Zero), .Timeout(Timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            Sub_FLAG   <= 1'b0;
            Sub_Result <= '0;
        end else begin
            Sub_FLAG   <= resp_en & Sub_Enable;
            Sub_Result <= Sub_A - Sub_B;
        end
    end

    int n_cmp = 0, n_bad = 0;
    int done_cyc, pulses;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run(input logic [15:0] a, input logic [15:0] b, input int inject_at);
        done_cyc = 0;
        pulses   = 0;
        @(posedge clk); #1;
        Dividend = a;
        Divisor  = b;
        start    = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (k + 1 == inject_at) begin
                start    = 1'b1;
                Dividend = 16'd9;
                Divisor  = 16'd3;
            end
            pulses += int'(Sub_Enable);
            if (Done) begin
                done_cyc = k + 1;
                break;
            end
        end
        start = 1'b0;
    endtask

    typedef struct {
        logic [15:0] a, b, q, r;
        int          cyc;
        logic        dz;
    } vec_t;
    vec_t tbl[9];

    initial begin
        int seen;
        tbl[0] = '{16'd100,   16'd7,     16'd14,    16'd2,     49, 1'b0};
        tbl[1] = '{16'hFFFF,  16'h8001,  16'd1,     16'h7FFE,  49, 1'b0};
        tbl[2] = '{16'd5,     16'd0,     16'hFFFF,  16'd5,     1,  1'b1};
        tbl[3] = '{16'd9,     16'd3,     16'd3,     16'd0,     49, 1'b0};
        tbl[4] = '{16'd0,     16'd5,     16'd0,     16'd0,     49, 1'b0};
        tbl[5] = '{16'hFFFF,  16'd1,     16'hFFFF,  16'd0,     49, 1'b0};
        tbl[6] = '{16'h1234,  16'hFFFF,  16'd0,     16'h1234,  49, 1'b0};
        tbl[7] = '{16'd50000, 16'd300,   16'd166,   16'd200,   49, 1'b0};
        tbl[8] = '{16'hFFFF,  16'hFFFF,  16'd1,     16'd0,     49, 1'b0};

        repeat (2) @(posedge clk); #1;
        chk("reset_busy", Busy, 0);
        chk("reset_done", Done, 0);
        chk("reset_quot", Quotient, 0);
        chk("reset_sub_en", Sub_Enable, 0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run(tbl[i].a, tbl[i].b, 0);
            chk($sformatf("vec%0d_quot", i), Quotient, tbl[i].q);
            chk($sformatf("vec%0d_rem", i), Remainder, tbl[i].r);
            chk($sformatf("vec%0d_cycle", i), done_cyc, tbl[i].cyc);
            chk($sformatf("vec%0d_pulses", i), pulses, tbl[i].dz ? 0 : 16);
            chk($sformatf("vec%0d_dz", i), Div_By_Zero, tbl[i].dz);
            chk($sformatf("vec%0d_timeout", i), Timeout, 0);
        end

        run(16'd100, 16'd7, 10);
        chk("restart_quot", Quotient, 14);
        chk("restart_rem", Remainder, 2);
        chk("restart_cycle", done_cyc, 49);

        @(posedge clk); #1;
        Dividend = 16'd100;
        Divisor  = 16'd7;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        chk("mid_busy", Busy, 1);
        rst = 1'b1;
        #1;
        chk("arst_busy", Busy, 0);
        chk("arst_done", Done, 0);
        chk("arst_quot", Quotient, 0);
        chk("arst_rem", Remainder, 0);
        chk("arst_sub_a", Sub_A, 0);
        chk("arst_sub_b", Sub_B, 0);
        chk("arst_sub_en", Sub_Enable, 0);
        chk("arst_dz", Div_By_Zero, 0);
        @(posedge clk); #1;
        rst  = 1'b0;
        seen = 0;
        repeat (60) begin
            @(posedge clk); #1;
            seen |= int'(Done);
        end
        chk("abandoned_no_done", seen, 0);
        run(16'd9, 16'd3, 0);
        chk("post_rst_quot", Quotient, 3);
        chk("post_rst_rem", Remainder, 0);

`ifdef DIV_TIMEOUT_EN
        resp_en = 1'b0;
        run(16'd100, 16'd7, 0);
        chk("to_flag", Timeout, 1);
        chk("to_quot", Quotient, 0);
        chk("to_rem", Remainder, 0);
        chk("to_cycle", done_cyc, 18);
        resp_en = 1'b1;
        run(16'd9, 16'd3, 0);
        chk("to_cleared", Timeout, 0);
        chk("to_next_quot", Quotient, 3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
